// File: rtl/id_ex_stage_pkg.sv
// Shared widths, control-bundle layout and the ID/EX register bundle for the decode/execute boundary.
// Imported by the ID/EX stage and the IF/ID stage controller.
package id_ex_stage_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int CTRL_W     = 16;

    // Control-bundle bit positions; EX and MEM decode the rest of the bundle.
    localparam int CTRL_MEM_READ   = 0;
    localparam int CTRL_MEM_WRITE  = 1;
    localparam int CTRL_REG_WRITE  = 2;
    localparam int CTRL_ALU_OP_LSB = 3;
    localparam int CTRL_ALU_OP_W   = 4;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic                  valid;
        logic [XLEN-1:0]       pc;
        logic [XLEN-1:0]       rs1_data;
        logic [XLEN-1:0]       rs2_data;
        logic [XLEN-1:0]       imm;
        logic [REG_ADDR_W-1:0] rs1_addr;
        logic [REG_ADDR_W-1:0] rs2_addr;
        logic [REG_ADDR_W-1:0] rd_addr;
        logic [CTRL_W-1:0]     ctrl;
    } id_ex_bundle_t;

    function automatic logic ctrl_is_load(input logic [CTRL_W-1:0] ctrl);
        return ctrl[CTRL_MEM_READ];
    endfunction

    function automatic logic [CTRL_ALU_OP_W-1:0] ctrl_alu_op(input logic [CTRL_W-1:0] ctrl);
        return ctrl[CTRL_ALU_OP_LSB +: CTRL_ALU_OP_W];
    endfunction

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Combinational load-use comparator: flags an ID instruction that reads the destination
// of a load currently in EX. Shared with the IF/ID stage controller.
module load_use_detect
    import id_ex_stage_pkg::*;
(
    input  logic                  ex_valid_i,
    input  logic                  ex_mem_read_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr_i,
    input  logic                  id_valid_i,
    input  logic                  id_uses_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
    input  logic                  id_uses_rs2_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
    output logic                  load_use_o
);

    logic ex_load_s;
    logic rs1_hit_s;
    logic rs2_hit_s;

    // A load to x0 produces nothing to wait for, so it never stalls.
    always_comb begin
        ex_load_s  = ex_valid_i && ex_mem_read_i && (ex_rd_addr_i != REG_ZERO);
        rs1_hit_s  = id_uses_rs1_i && (id_rs1_addr_i == ex_rd_addr_i);
        rs2_hit_s  = id_uses_rs2_i && (id_rs2_addr_i == ex_rd_addr_i);
        if (ex_load_s && id_valid_i) begin
            load_use_o = rs1_hit_s || rs2_hit_s;
        end else begin
            load_use_o = 1'b0;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures operands (with same-cycle writeback bypass), immediate and
// control, inserts load-use bubbles, and honours EX stall and branch flush.
module id_ex_stage
    import id_ex_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [XLEN-1:0]       id_pc,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [XLEN-1:0]       id_rs1_data,
    input  logic [XLEN-1:0]       id_rs2_data,
    input  logic [REG_ADDR_W-1:0] id_rd_addr,
    input  logic [XLEN-1:0]       id_imm,
    input  logic [CTRL_W-1:0]     id_ctrl,
    input  logic                  wb_reg_write_en,
    input  logic [REG_ADDR_W-1:0] wb_rd_addr,
    input  logic [XLEN-1:0]       wb_rd_data,
    input  logic                  ex_stall,
    input  logic                  flush,
    output logic                  stall_if_id,
    output logic                  ex_valid,
    output logic [XLEN-1:0]       ex_pc,
    output logic [XLEN-1:0]       ex_rs1_data,
    output logic [XLEN-1:0]       ex_rs2_data,
    output logic [XLEN-1:0]       ex_imm,
    output logic [REG_ADDR_W-1:0] ex_rs1_addr,
    output logic [REG_ADDR_W-1:0] ex_rs2_addr,
    output logic [REG_ADDR_W-1:0] ex_rd_addr,
    output logic [CTRL_W-1:0]     ex_ctrl
);

    id_ex_bundle_t   ex_q;
    id_ex_bundle_t   ex_d;
    logic            load_use_s;
    logic            wb_live_s;
    logic [XLEN-1:0] rs1_fwd_s;
    logic [XLEN-1:0] rs2_fwd_s;

    load_use_detect u_load_use_detect (
        .ex_valid_i    (ex_q.valid),
        .ex_mem_read_i (ctrl_is_load(ex_q.ctrl)),
        .ex_rd_addr_i  (ex_q.rd_addr),
        .id_valid_i    (id_valid),
        .id_uses_rs1_i (id_uses_rs1),
        .id_rs1_addr_i (id_rs1_addr),
        .id_uses_rs2_i (id_uses_rs2),
        .id_rs2_addr_i (id_rs2_addr),
        .load_use_o    (load_use_s)
    );

    // The register file writes on the edge, so this cycle's writeback is not yet on its read ports.
    always_comb begin
        wb_live_s = wb_reg_write_en && (wb_rd_addr != REG_ZERO);
        if (wb_live_s && (wb_rd_addr == id_rs1_addr)) begin
            rs1_fwd_s = wb_rd_data;
        end else begin
            rs1_fwd_s = id_rs1_data;
        end
        if (wb_live_s && (wb_rd_addr == id_rs2_addr)) begin
            rs2_fwd_s = wb_rd_data;
        end else begin
            rs2_fwd_s = id_rs2_data;
        end
    end

    // Next EX contents: flush beats stall, stall beats the load-use bubble.
    always_comb begin
        ex_d = ex_q;
        if (flush) begin
            ex_d = '0;
        end else if (ex_stall) begin
            ex_d = ex_q;
        end else if (load_use_s) begin
            ex_d = '0;
        end else begin
            ex_d.valid    = id_valid;
            ex_d.pc       = id_pc;
            ex_d.rs1_data = rs1_fwd_s;
            ex_d.rs2_data = rs2_fwd_s;
            ex_d.imm      = id_imm;
            ex_d.rs1_addr = id_rs1_addr;
            ex_d.rs2_addr = id_rs2_addr;
            ex_d.rd_addr  = id_rd_addr;
            if (id_valid) begin
                ex_d.ctrl = id_ctrl;
            end else begin
                ex_d.ctrl = '0;
            end
        end
    end

    // Upstream hold request; a flush discards the ID instruction, so nothing needs holding.
    always_comb begin
        if (rst && !flush) begin
            stall_if_id = ex_stall || load_use_s;
        end else begin
            stall_if_id = 1'b0;
        end
    end

    // Pipeline register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign ex_valid    = ex_q.valid;
    assign ex_pc       = ex_q.pc;
    assign ex_rs1_data = ex_q.rs1_data;
    assign ex_rs2_data = ex_q.rs2_data;
    assign ex_imm      = ex_q.imm;
    assign ex_rs1_addr = ex_q.rs1_addr;
    assign ex_rs2_addr = ex_q.rs2_addr;
    assign ex_rd_addr  = ex_q.rd_addr;
    assign ex_ctrl     = ex_q.ctrl;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed and randomized bench for id_ex_stage against a behavioural model of the EX-side state.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  id_valid;
    logic [XLEN-1:0]       id_pc;
    logic [REG_ADDR_W-1:0] id_rs1_addr;
    logic [REG_ADDR_W-1:0] id_rs2_addr;
    logic                  id_uses_rs1;
    logic                  id_uses_rs2;
    logic [XLEN-1:0]       id_rs1_data;
    logic [XLEN-1:0]       id_rs2_data;
    logic [REG_ADDR_W-1:0] id_rd_addr;
    logic [XLEN-1:0]       id_imm;
    logic [CTRL_W-1:0]     id_ctrl;
    logic                  wb_reg_write_en;
    logic [REG_ADDR_W-1:0] wb_rd_addr;
    logic [XLEN-1:0]       wb_rd_data;
    logic                  ex_stall;
    logic                  flush;
    logic                  stall_if_id;
    logic                  ex_valid;
    logic [XLEN-1:0]       ex_pc;
    logic [XLEN-1:0]       ex_rs1_data;
    logic [XLEN-1:0]       ex_rs2_data;
    logic [XLEN-1:0]       ex_imm;
    logic [REG_ADDR_W-1:0] ex_rs1_addr;
    logic [REG_ADDR_W-1:0] ex_rs2_addr;
    logic [REG_ADDR_W-1:0] ex_rd_addr;
    logic [CTRL_W-1:0]     ex_ctrl;

    int checks = 0;
    int errors = 0;

    // Model of what EX should hold; m_dc marks a load-use bubble whose data fields are unspecified.
    logic                  m_valid = 1'b0;
    logic [XLEN-1:0]       m_pc = '0, m_rs1d = '0, m_rs2d = '0, m_imm = '0;
    logic [REG_ADDR_W-1:0] m_rs1a = '0, m_rs2a = '0, m_rda = '0;
    logic [CTRL_W-1:0]     m_ctrl = '0;
    bit                    m_dc = 1'b0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_rd_addr(id_rd_addr), .id_imm(id_imm), .id_ctrl(id_ctrl),
        .wb_reg_write_en(wb_reg_write_en), .wb_rd_addr(wb_rd_addr), .wb_rd_data(wb_rd_data),
        .ex_stall(ex_stall), .flush(flush), .stall_if_id(stall_if_id),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_imm(ex_imm), .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr),
        .ex_rd_addr(ex_rd_addr), .ex_ctrl(ex_ctrl)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // What EX will read for a source register this cycle: the value being written back wins over the stale file.
    function automatic logic [XLEN-1:0] operand(input logic [REG_ADDR_W-1:0] a, input logic [XLEN-1:0] file_val);
        if (wb_reg_write_en && a != 5'd0 && a == wb_rd_addr) return wb_rd_data;
        return file_val;
    endfunction

    // One clock: check the hold request mid-cycle, advance the model, check EX after the edge.
    task automatic step();
        logic waits_on_load;
        logic exp_stall;
        @(negedge clk);
        waits_on_load = m_valid && m_ctrl[CTRL_MEM_READ] && (m_rda != 5'd0) && id_valid &&
                        ((id_uses_rs1 && id_rs1_addr == m_rda) || (id_uses_rs2 && id_rs2_addr == m_rda));
        exp_stall = rst && !flush && (ex_stall || waits_on_load);
        chk("stall_if_id", {63'd0, stall_if_id}, {63'd0, exp_stall});
        if (!rst || flush) begin
            m_valid = 1'b0; m_pc = '0; m_rs1d = '0; m_rs2d = '0; m_imm = '0;
            m_rs1a = '0; m_rs2a = '0; m_rda = '0; m_ctrl = '0; m_dc = 1'b0;
        end else if (!ex_stall) begin
            if (waits_on_load) begin
                m_valid = 1'b0; m_ctrl = '0; m_dc = 1'b1;
            end else begin
                m_valid = id_valid; m_pc = id_pc; m_imm = id_imm;
                m_rs1d = operand(id_rs1_addr, id_rs1_data);
                m_rs2d = operand(id_rs2_addr, id_rs2_data);
                m_rs1a = id_rs1_addr; m_rs2a = id_rs2_addr; m_rda = id_rd_addr;
                m_ctrl = id_valid ? id_ctrl : 16'd0;
                m_dc = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        chk("ex_valid", {63'd0, ex_valid}, {63'd0, m_valid});
        chk("ex_ctrl", {48'd0, ex_ctrl}, {48'd0, m_ctrl});
        if (!m_dc) begin
            chk("ex_pc", {32'd0, ex_pc}, {32'd0, m_pc});
            chk("ex_rs1_data", {32'd0, ex_rs1_data}, {32'd0, m_rs1d});
            chk("ex_rs2_data", {32'd0, ex_rs2_data}, {32'd0, m_rs2d});
            chk("ex_imm", {32'd0, ex_imm}, {32'd0, m_imm});
            chk("ex_rs1_addr", {59'd0, ex_rs1_addr}, {59'd0, m_rs1a});
            chk("ex_rs2_addr", {59'd0, ex_rs2_addr}, {59'd0, m_rs2a});
            chk("ex_rd_addr", {59'd0, ex_rd_addr}, {59'd0, m_rda});
        end
    endtask

    task automatic set_id(input logic [XLEN-1:0] pc, input logic [4:0] r1, input logic [XLEN-1:0] d1,
                          input logic [4:0] r2, input logic [XLEN-1:0] d2, input logic [4:0] rd,
                          input logic [XLEN-1:0] imm, input logic [CTRL_W-1:0] ctrl);
        id_valid = 1'b1; id_pc = pc; id_rs1_addr = r1; id_rs1_data = d1; id_rs2_addr = r2;
        id_rs2_data = d2; id_rd_addr = rd; id_imm = imm; id_ctrl = ctrl;
        id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1;
    endtask

    task automatic set_wb(input logic en, input logic [4:0] rd, input logic [XLEN-1:0] d);
        wb_reg_write_en = en; wb_rd_addr = rd; wb_rd_data = d;
    endtask

    initial begin
        rst = 1'b0; ex_stall = 1'b1; flush = 1'b0;
        set_id(32'h0000_0ABC, 5'd1, 32'h1111_1111, 5'd2, 32'h2222_2222, 5'd3, 32'h7, 16'hFFFF);
        set_wb(1'b1, 5'd1, 32'h5555_5555);
        // Reset with busy inputs: EX stays empty and no hold is requested.
        step(); step();
        rst = 1'b1; ex_stall = 1'b0; set_wb(1'b0, 5'd0, 32'd0);
        set_id(32'h100, 5'd5, 32'h11, 5'd6, 32'h22, 5'd7, 32'h4, 16'h0004);
        step();
        set_wb(1'b1, 5'd5, 32'hDEAD_BEEF);
        set_id(32'h104, 5'd5, 32'h11, 5'd6, 32'h22, 5'd8, 32'h8, 16'h0004);
        step();
        set_wb(1'b1, 5'd0, 32'h1234_5678);
        set_id(32'h108, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 32'hC, 16'h0004);
        step();
        set_wb(1'b1, 5'd9, 32'h0000_CAFE);
        set_id(32'h10C, 5'd3, 32'h33, 5'd9, 32'h99, 5'd10, 32'h10, 16'h0004);
        step();
        // lw x5 followed by a dependent add: one bubble, then the add picks up the load from WB.
        set_wb(1'b0, 5'd0, 32'd0);
        set_id(32'h110, 5'd1, 32'h0, 5'd0, 32'h0, 5'd5, 32'h0, 16'h0001);
        step();
        set_id(32'h114, 5'd5, 32'h11, 5'd6, 32'h22, 5'd8, 32'h0, 16'h0004);
        step();
        set_wb(1'b1, 5'd5, 32'hA5A5_A5A5);
        step();
        set_wb(1'b0, 5'd0, 32'd0);
        set_id(32'h118, 5'd1, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 16'h0001);
        step();
        set_id(32'h11C, 5'd0, 32'h0, 5'd0, 32'h0, 5'd4, 32'h0, 16'h0004);
        step();
        set_id(32'h120, 5'd1, 32'h0, 5'd0, 32'h0, 5'd6, 32'h0, 16'h0001);
        step();
        set_id(32'h124, 5'd2, 32'h2, 5'd6, 32'h66, 5'd4, 32'h0, 16'h0004);
        id_uses_rs2 = 1'b0;
        step();
        // Three-cycle EX stall with a flush in the middle cycle.
        set_id(32'h128, 5'd7, 32'h77, 5'd8, 32'h88, 5'd9, 32'h0, 16'h0008);
        ex_stall = 1'b1;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        ex_stall = 1'b0;
        step();
        // Reset arriving while a load-use hold is pending.
        set_id(32'h130, 5'd1, 32'h0, 5'd0, 32'h0, 5'd5, 32'h0, 16'h0001);
        step();
        set_id(32'h134, 5'd5, 32'h11, 5'd5, 32'h11, 5'd6, 32'h0, 16'h0004);
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
        // Randomized traffic over a small register window to provoke hazards and bypasses.
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 39) != 0);
            ex_stall = ($urandom_range(0, 5) == 0);
            flush = ($urandom_range(0, 9) == 0);
            id_valid = ($urandom_range(0, 4) != 0);
            id_pc = $urandom; id_imm = $urandom;
            id_rs1_addr = 5'($urandom_range(0, 3)); id_rs2_addr = 5'($urandom_range(0, 3));
            id_rd_addr = 5'($urandom_range(0, 3));
            id_uses_rs1 = 1'($urandom_range(0, 1)); id_uses_rs2 = 1'($urandom_range(0, 1));
            id_rs1_data = $urandom; id_rs2_data = $urandom;
            id_ctrl = 16'($urandom);
            wb_reg_write_en = 1'($urandom_range(0, 1));
            wb_rd_addr = 5'($urandom_range(0, 3)); wb_rd_data = $urandom;
            step();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline stage that sits directly downstream of the register file.
- Captures the register-file read data, immediate and control bundle for the instruction in ID, and presents them registered to EX.
- Bypasses a same-cycle writeback to the register file, because the register file writes on the clock edge and reads combinationally, so a write in the current cycle is not yet visible on its read ports.
- Detects load-use hazards, inserts bubbles, and honours downstream stall and branch flush.

Parameters:
- XLEN, 32, datapath width.
- REG_ADDR_W, 5, register address width.
- CTRL_W, 16, width of the opaque control bundle passed to EX.
- CTRL_MEM_READ, 0, bit index in the control bundle that marks a load.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-low
- id_valid  input  1  ID holds a real instruction
- id_pc  input  XLEN  PC of the ID instruction
- id_rs1_addr  input  REG_ADDR_W  source 1 address (also drives the register file)
- id_rs2_addr  input  REG_ADDR_W  source 2 address
- id_uses_rs1  input  1  instruction reads rs1
- id_uses_rs2  input  1  instruction reads rs2
- id_rs1_data  input  XLEN  register file read data, port 1
- id_rs2_data  input  XLEN  register file read data, port 2
- id_rd_addr  input  REG_ADDR_W  destination register
- id_imm  input  XLEN  decoded immediate
- id_ctrl  input  CTRL_W  decoded control bundle
- wb_reg_write_en  input  1  same signal that drives the register file write enable
- wb_rd_addr  input  REG_ADDR_W  writeback destination
- wb_rd_data  input  XLEN  writeback data
- ex_stall  input  1  EX busy (e.g. multi-cycle divide); hold this stage
- flush  input  1  branch/jump taken in EX; kill the ID instruction
- stall_if_id  output  1  combinational; hold PC and the IF/ID register
- ex_valid  output  1  EX holds a real instruction
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  output  XLEN  registered copies
- ex_rs1_addr, ex_rs2_addr, ex_rd_addr  output  REG_ADDR_W  registered copies (for the EX forwarding unit)
- ex_ctrl  output  CTRL_W  registered control bundle

Behaviour:
- All ex_* outputs are registers updated on posedge clk. Latency from ID to EX is 1 cycle.
- Reset: rst==0 at posedge clears every ex_* register to 0, including ex_valid=0 and ex_ctrl=0. stall_if_id is driven 0 while rst==0.
- Update priority per edge: reset > flush > ex_stall > load-use > normal.
  - flush=1: ex_valid<=0 and ex_ctrl<=0; other fields are don't-care (cleared). flush overrides ex_stall.
  - ex_stall=1 (no flush): all ex_* registers hold; stall_if_id=1.
  - Load-use: a hazard exists when ex_valid && ex_ctrl[CTRL_MEM_READ] && ex_rd_addr!=0 && id_valid, and either (id_uses_rs1 && id_rs1_addr==ex_rd_addr) or (id_uses_rs2 && id_rs2_addr==ex_rd_addr).
    - Response: stall_if_id=1; next edge inserts a bubble (ex_valid<=0, ex_ctrl<=0).
    - One bubble clears the hazard, because the load leaves EX.
  - Normal: ex_valid<=id_valid and all fields captured. If id_valid==0, ex_ctrl<=0.
- WB bypass, applied independently per source:
  - If wb_reg_write_en && wb_rd_addr!=0 && wb_rd_addr==id_rsN_addr, capture wb_rd_data.
  - Otherwise capture id_rsN_data.
  - Address 0 never bypasses, so x0 stays 0.
- stall_if_id = rst && (ex_stall || load_use) && !flush.
- Reset mid-stall: all state clears; no hazard persists after reset.
- No operand recapture while holding. Forwarding from MEM/WB into a held EX instruction belongs to the EX forwarding unit.

Decomposition:
- Shared package:
  - XLEN, REG_ADDR_W, CTRL_W.
  - Control-bundle bit indices (CTRL_MEM_READ, CTRL_MEM_WRITE, CTRL_REG_WRITE, ALU op field positions).
  - REG_ZERO constant.
- One sub-module: load_use_detect, the combinational hazard comparator. It is reused by the IF/ID stage controller.
- The bypass muxes stay inline.

Test Plan:
- Reset: rst=0 for 2 cycles with id_valid=1 and nonzero inputs -> all ex_* read 0 and stall_if_id=0. Release -> capture begins on the next edge.
- Normal capture: id_pc=0x100, rs1=x5 data 0x11, rs2=x6 data 0x22, rd=x7, imm=0x4 -> one cycle later ex_rs1_data=0x11, ex_rs2_data=0x22, ex_rd_addr=7, ex_pc=0x100, ex_valid=1.
- WB bypass:
  - wb writes x5=0xDEADBEEF in the same cycle ID reads x5 with stale data 0x11 -> ex_rs1_data=0xDEADBEEF.
  - wb_rd_addr=0 with id_rs1_addr=0 -> ex_rs1_data=0.
  - A bypass that matches only rs2 -> only ex_rs2_data is affected.
- Load-use:
  - EX holds lw x5 and ID holds add using x5 -> stall_if_id=1 for exactly 1 cycle, one bubble with ex_valid=0, then add captured with the load value bypassed from WB.
  - lw x0 -> no stall.
  - Match on rs2 with id_uses_rs2=0 -> no stall.
- ex_stall held 3 cycles -> ex_* frozen and stall_if_id=1 each cycle. Assert flush in cycle 2 -> ex_valid=0 next edge and stall_if_id=0 that cycle.
- Reset asserted during a load-use stall -> next edge all ex_* are 0, with no residual bubble or stall after release.
